// File: rtl/controlador_motores_pkg.sv
// Shared definitions for the dual-motor sequencer.
// Contents:
//   estado_t            3-bit FSM state encoding (also visible on the ESTADO debug port)
//   T_*_DEF             default timing constants (cycles)
//   motor1_de/motor2_de Moore output decode of a state value
package controlador_motores_pkg;

  typedef enum logic [2:0] {
    INACTIVO  = 3'd0,
    ALT_M1    = 3'd1,
    ALT_P1    = 3'd2,
    ALT_M2    = 3'd3,
    ALT_P2    = 3'd4,
    ESC_M1    = 3'd5,
    ESC_AMBOS = 3'd6,
    PARADA    = 3'd7
  } estado_t;

  localparam int unsigned T_ON_DEF  = 8;
  localparam int unsigned T_GAP_DEF = 2;
  localparam int unsigned T_ESC_DEF = 4;

  function automatic logic motor1_de(input estado_t e);
    return (e == ALT_M1) || (e == ESC_M1) || (e == ESC_AMBOS) || (e == PARADA);
  endfunction

  function automatic logic motor2_de(input estado_t e);
    return (e == ALT_M2) || (e == ESC_AMBOS);
  endfunction

endpackage

// File: rtl/controlador_motores_temporizador.sv
// temporizador_motor: state-duration timer for the motor sequencer.
// Ports:
//   CLK       clock, rising edge
//   REINICIO  synchronous active-low reset
//   limpiar   clear the count (asserted on every state change)
//   habilitar count while the current state is timed
//   limite    duration of the current state in cycles
//   cuenta    current count
//   fin       last cycle of the current timed state
module temporizador_motor #(
  parameter int unsigned ANCHO_CONT = 8
) (
  input  logic                  CLK,
  input  logic                  REINICIO,
  input  logic                  limpiar,
  input  logic                  habilitar,
  input  logic [ANCHO_CONT-1:0] limite,
  output logic [ANCHO_CONT-1:0] cuenta,
  output logic                  fin
);

  logic [ANCHO_CONT-1:0] r_cuenta;

  always_ff @(posedge CLK) begin
    if (!REINICIO) begin
      r_cuenta <= '0;
    end else if (limpiar) begin
      r_cuenta <= '0;
    end else if (habilitar) begin
      r_cuenta <= r_cuenta + ANCHO_CONT'(1);
    end
  end

  assign cuenta = r_cuenta;
  assign fin    = habilitar && (r_cuenta == limite - ANCHO_CONT'(1));

endmodule

// File: rtl/controlador_motores.sv
// controlador_motores: dual-motor sequencer (alternating or staggered).
// Ports:
//   CLK       clock, rising edge
//   REINICIO  synchronous active-low reset
//   ARRANQUE  run request, level-sensitive
//   MODO      1 = alternating, 0 = staggered; sampled only when starting
//   MOTOR1    motor 1 enable (registered)
//   MOTOR2    motor 2 enable (registered)
//   ESTADO    current FSM state, for debug
module controlador_motores
  import controlador_motores_pkg::*;
#(
  parameter int unsigned T_ON       = T_ON_DEF,
  parameter int unsigned T_GAP      = T_GAP_DEF,
  parameter int unsigned T_ESC      = T_ESC_DEF,
  parameter int unsigned ANCHO_CONT = 8
) (
  input  logic       CLK,
  input  logic       REINICIO,
  input  logic       ARRANQUE,
  input  logic       MODO,
  output logic       MOTOR1,
  output logic       MOTOR2,
  output logic [2:0] ESTADO
);

  estado_t               r_estado;
  estado_t               w_estado_d;
  logic                  r_modo_lat;
  logic                  r_motor1;
  logic                  r_motor2;
  logic [ANCHO_CONT-1:0] w_limite;
  logic [ANCHO_CONT-1:0] w_cuenta;
  logic                  w_habilitar;
  logic                  w_limpiar;
  logic                  w_fin;
  logic                  w_desborde;

  // Duration of the current state; untimed states keep the timer idle.
  always_comb begin
    w_habilitar = 1'b1;
    w_limite    = '0;
    case (r_estado)
      ALT_M1, ALT_M2:         w_limite = ANCHO_CONT'(T_ON);
      ALT_P1, ALT_P2, PARADA: w_limite = ANCHO_CONT'(T_GAP);
      ESC_M1:                 w_limite = ANCHO_CONT'(T_ESC);
      default:                w_habilitar = 1'b0;
    endcase
  end

  // Count past the limit cannot happen in normal operation; treat it as a fault.
  assign w_desborde = w_habilitar && (w_cuenta >= w_limite);

  always_comb begin
    w_estado_d = r_estado;
    case (r_estado)
      INACTIVO: if (ARRANQUE) w_estado_d = MODO ? ALT_M1 : ESC_M1;
      ALT_M1, ALT_P1, ALT_M2, ALT_P2: begin
        // A staggered latch here is unreachable; abort rather than continue.
        if (!ARRANQUE || !r_modo_lat) begin
          w_estado_d = INACTIVO;
        end else if (w_fin) begin
          case (r_estado)
            ALT_M1:  w_estado_d = ALT_P1;
            ALT_P1:  w_estado_d = ALT_M2;
            ALT_M2:  w_estado_d = ALT_P2;
            default: w_estado_d = ALT_M1;
          endcase
        end
      end
      ESC_M1: begin
        if (!ARRANQUE)  w_estado_d = PARADA;
        else if (w_fin) w_estado_d = ESC_AMBOS;
      end
      ESC_AMBOS: if (!ARRANQUE) w_estado_d = PARADA;
      PARADA:    if (w_fin) w_estado_d = INACTIVO;
      default:   w_estado_d = INACTIVO;
    endcase
    if (w_desborde) w_estado_d = INACTIVO;
  end

  assign w_limpiar = (w_estado_d != r_estado);

  temporizador_motor #(
    .ANCHO_CONT(ANCHO_CONT)
  ) u_temporizador (
    .CLK      (CLK),
    .REINICIO (REINICIO),
    .limpiar  (w_limpiar),
    .habilitar(w_habilitar),
    .limite   (w_limite),
    .cuenta   (w_cuenta),
    .fin      (w_fin)
  );

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (!REINICIO) begin
      r_estado   <= INACTIVO;
      r_modo_lat <= 1'b0;
      r_motor1   <= 1'b0;
      r_motor2   <= 1'b0;
    end else begin
      r_estado <= w_estado_d;
      if ((r_estado == INACTIVO) && ARRANQUE) r_modo_lat <= MODO;
      r_motor1 <= motor1_de(w_estado_d);
      r_motor2 <= motor2_de(w_estado_d);
    end
  end

  assign MOTOR1 = r_motor1;
  assign MOTOR2 = r_motor2;
  assign ESTADO = r_estado;

endmodule

// File: tb/tb_controlador_motores.sv
// Self-checking bench for controlador_motores: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_controlador_motores;

  localparam int TON    = 8;
  localparam int TGAP   = 2;
  localparam int TESC   = 4;
  localparam int PERIOD = 2 * (TON + TGAP);

  logic       CLK = 1'b0;
  logic       REINICIO = 1'b0;
  logic       ARRANQUE = 1'b0;
  logic       MODO = 1'b0;
  logic       MOTOR1;
  logic       MOTOR2;
  logic [2:0] ESTADO;

  controlador_motores dut (
    .CLK     (CLK),
    .REINICIO(REINICIO),
    .ARRANQUE(ARRANQUE),
    .MODO    (MODO),
    .MOTOR1  (MOTOR1),
    .MOTOR2  (MOTOR2),
    .ESTADO  (ESTADO)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 running, 2 staggered run-down.
  int m_st  = 0;
  bit m_alt = 0;
  int m_p   = 0;  // cycles since start
  int m_q   = 0;  // cycles since stop request

  function automatic void model_edge(input bit rst, input bit arr, input bit modo);
    if (!rst) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (arr) begin
        m_st = 1; m_alt = modo; m_p = 0;
      end
    end else if (m_st == 1) begin
      if (!arr) begin
        if (m_alt) m_st = 0;
        else begin m_st = 2; m_q = 0; end
      end else if (m_alt) begin
        m_p = (m_p + 1) % PERIOD;
      end else if (m_p < 1000) begin
        m_p++;
      end
    end else begin
      m_q++;
      if (m_q == TGAP) m_st = 0;
    end
  endfunction

  function automatic int exp_m1();
    if (m_st == 0) return 0;
    if (m_st == 2) return 1;
    if (m_alt) return (m_p < TON) ? 1 : 0;
    return 1;
  endfunction

  function automatic int exp_m2();
    if (m_st != 1) return 0;
    if (m_alt) return (m_p >= TON + TGAP && m_p < 2 * TON + TGAP) ? 1 : 0;
    return (m_p >= TESC) ? 1 : 0;
  endfunction

  function automatic int exp_est();
    if (m_st == 0) return 0;
    if (m_st == 2) return 7;
    if (!m_alt) return (m_p < TESC) ? 5 : 6;
    if (m_p < TON) return 1;
    if (m_p < TON + TGAP) return 2;
    if (m_p < 2 * TON + TGAP) return 3;
    return 4;
  endfunction

  task automatic step(input bit rst, input bit arr, input bit modo);
    @(negedge CLK);
    REINICIO = rst; ARRANQUE = arr; MODO = modo;
    @(posedge CLK);
    model_edge(rst, arr, modo);
    #1;
    chk("exclusion_alt", int'(MOTOR1 && MOTOR2 && (ESTADO inside {3'd1, 3'd2, 3'd3, 3'd4})), 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_motor1"}, int'(MOTOR1), exp_m1());
    chk({tag, "_motor2"}, int'(MOTOR2), exp_m2());
    chk({tag, "_estado"}, int'(ESTADO), exp_est());
  endtask

  task automatic chk_out(input string tag, input int m1, input int m2, input int est);
    chk({tag, "_motor1"}, int'(MOTOR1), m1);
    chk({tag, "_motor2"}, int'(MOTOR2), m2);
    chk({tag, "_estado"}, int'(ESTADO), est);
  endtask

  typedef struct {
    bit rst;
    bit arr;
    bit modo;
    int m1;
    int m2;
    int est;
  } vec_t;

  vec_t tab[$];

  task automatic add(input int n, input bit rst, input bit arr, input bit modo,
                     input int m1, input int m2, input int est);
    vec_t v;
    v.rst = rst; v.arr = arr; v.modo = modo; v.m1 = m1; v.m2 = m2; v.est = est;
    for (int i = 0; i < n; i++) tab.push_back(v);
  endtask

  initial begin
    // Reset hold, then alternating start at edge k with MODO pulsed low at k+3 and k+12.
    add(3, 0, 1, 1, 0, 0, 0);
    add(3, 1, 1, 1, 1, 0, 1);  // k..k+2
    add(1, 1, 1, 0, 1, 0, 1);  // k+3
    add(4, 1, 1, 1, 1, 0, 1);  // k+4..k+7
    add(2, 1, 1, 1, 0, 0, 2);  // k+8..k+9
    add(2, 1, 1, 1, 0, 1, 3);  // k+10..k+11
    add(1, 1, 1, 0, 0, 1, 3);  // k+12
    add(5, 1, 1, 1, 0, 1, 3);  // k+13..k+17
    add(2, 1, 1, 1, 0, 0, 4);  // k+18..k+19
    add(1, 1, 1, 1, 1, 0, 1);  // k+20

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].rst, tab[i].arr, tab[i].modo);
      chk_out($sformatf("vec%0d", i), tab[i].m1, tab[i].m2, tab[i].est);
    end

    // Alternating abort in ALT_M2: immediate stop, no gap.
    step(0, 1, 1);
    step(1, 1, 1);
    for (int i = 1; i < 12; i++) step(1, 1, 1);
    chk_out("abort_pre", 0, 1, 3);
    step(1, 0, 1);
    chk_out("abort_k12", 0, 0, 0);
    step(1, 0, 1);
    chk_model("abort_after");

    // Staggered start, ordered stop, restart from a still-high ARRANQUE.
    step(0, 0, 0);
    step(1, 1, 0);
    chk_out("esc_k", 1, 0, 5);
    for (int i = 1; i < 4; i++) begin
      step(1, 1, 0);
      chk_out("esc_m1only", 1, 0, 5);
    end
    step(1, 1, 0);
    chk_out("esc_k4", 1, 1, 6);
    for (int i = 0; i < 5; i++) step(1, 1, 1);
    chk_out("esc_hold", 1, 1, 6);
    step(1, 0, 1);
    chk_out("parada_j", 1, 0, 7);
    step(1, 1, 1);
    chk_out("parada_j1", 1, 0, 7);
    step(1, 1, 1);
    chk_out("parada_j2", 0, 0, 0);
    step(1, 1, 1);
    chk_out("restart_alt", 1, 0, 1);

    // Reset in ESC_AMBOS: both off at once, no run-down, fresh start latches MODO.
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    chk_out("rst_pre", 1, 1, 6);
    step(0, 1, 0);
    chk_out("rst_mid", 0, 0, 0);
    step(1, 1, 1);
    chk_out("rst_fresh", 1, 0, 1);
    step(1, 1, 1);
    chk_model("rst_fresh_model");

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      bit rst, arr, modo;
      rst  = ($urandom_range(0, 79) != 0);
      arr  = ($urandom_range(0, 15) != 0);
      modo = $urandom_range(0, 1) != 0;
      step(rst, arr, modo);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_motores.md
Name: controlador_motores

Overview:
Dual-motor sequencer. It consumes the bench/panel control signals CLK, REINICIO, ARRANQUE and MODO, and produces the MOTOR1 and MOTOR2 drive enables. Mode selection picks between two sequences:
- Alternating (MODO=1): motors run one after the other with dead gaps.
- Staggered (MODO=0): MOTOR1 starts first, MOTOR2 joins later, and shutdown is ordered.

Parameters:
- T_ON, 8: cycles each motor runs per alternating phase (>=1).
- T_GAP, 2: dead-gap cycles between alternating phases; also the MOTOR1 run-down cycles in staggered stop (>=1).
- T_ESC, 4: cycles MOTOR1 runs alone before MOTOR2 joins in staggered mode (>=1).
- ANCHO_CONT, 8: timer width; must hold max(T_ON, T_GAP, T_ESC).

Ports:
- CLK, input, 1: single clock, rising edge.
- REINICIO, input, 1: reset, synchronous, active-low.
- ARRANQUE, input, 1: run request; level-sensitive.
- MODO, input, 1: 1 = alternating, 0 = staggered; sampled only when starting.
- MOTOR1, output, 1: motor 1 enable.
- MOTOR2, output, 1: motor 2 enable.
- ESTADO, output, 3: current FSM state, for debug and verification.

Behaviour:
- Edge k is the rising edge of CLK; cycle k is the interval after edge k. Outputs are a Moore decode of the state register, so they change on the same edge as the state.
- Reset: REINICIO=0 at any edge forces the following values at that edge, regardless of other inputs:
  - state = INACTIVO (0)
  - timer = 0
  - modo_lat = 0
  - MOTOR1 = 0, MOTOR2 = 0
- States and encodings:
  - INACTIVO = 0
  - ALT_M1 = 1
  - ALT_P1 = 2
  - ALT_M2 = 3
  - ALT_P2 = 4
  - ESC_M1 = 5
  - ESC_AMBOS = 6
  - PARADA = 7
- Output decode:
  - MOTOR1 = 1 in ALT_M1, ESC_M1, ESC_AMBOS and PARADA.
  - MOTOR2 = 1 in ALT_M2 and ESC_AMBOS.
- Timer behaviour:
  - Counts up while in a timed state and clears on every state change.
  - A timed state with duration T lasts exactly T cycles, then exits on the edge where timer == T-1.
- INACTIVO: if ARRANQUE=1 at an edge, latch modo_lat <= MODO at that edge and go to ALT_M1 (MODO=1) or ESC_M1 (MODO=0). Latency from sampled ARRANQUE to motor on is 0 cycles, i.e. the motor is on in cycle k.
- Alternating sequence:
  - ALT_M1 (T_ON) -> ALT_P1 (T_GAP) -> ALT_M2 (T_ON) -> ALT_P2 (T_GAP) -> ALT_M1, repeating.
  - ARRANQUE=0 at any edge in an ALT_* state -> INACTIVO at that edge, with immediate stop.
  - MOTOR1 and MOTOR2 are never both 1 in alternating mode.
- Staggered sequence:
  - ESC_M1 runs for T_ESC cycles, then goes to ESC_AMBOS.
  - ESC_AMBOS holds indefinitely while ARRANQUE=1.
  - ARRANQUE=0 in ESC_M1 or ESC_AMBOS -> PARADA at that edge.
  - PARADA: MOTOR1 only, for T_GAP cycles, then INACTIVO.
  - ARRANQUE is ignored during PARADA. Once in INACTIVO, a still-high ARRANQUE restarts on the next edge.
- MODO changes while the FSM is not INACTIVO are ignored; the sequence follows modo_lat.
- Reset mid-operation: both motors go off at that edge. There is no PARADA run-down.
- Unused or illegal state values are unreachable; the default branch goes to INACTIVO.

Decomposition:
- Shared package (controlador_motores_pkg) holds:
  - the 3-bit state localparams listed above;
  - default timing constants T_ON_DEF = 8, T_GAP_DEF = 2, T_ESC_DEF = 4.
- One sub-module, temporizador_motor:
  - Ports: CLK, REINICIO, limpiar, habilitar, limite [ANCHO_CONT-1:0], cuenta, fin.
  - fin = habilitar && cuenta == limite-1.
- The top-level block holds the FSM, the modo_lat register and the output decode.

Test Plan:
- Reset hold: REINICIO=0 for 3 edges with ARRANQUE=1, MODO=1 -> MOTOR1=0, MOTOR2=0 and ESTADO=0 throughout. After release, the first start is at the next edge with ARRANQUE=1.
- Alternating, ARRANQUE=1 and MODO=1 sampled at edge k, defaults:
  - MOTOR1=1 in cycles k..k+7;
  - both 0 in k+8..k+9;
  - MOTOR2=1 in k+10..k+17;
  - both 0 in k+18..k+19;
  - MOTOR1=1 again from k+20;
  - assert MOTOR1&MOTOR2 is never 1.
- Staggered, MODO=0 at edge k:
  - MOTOR1=1 from cycle k, MOTOR2=1 from cycle k+4;
  - ARRANQUE=0 sampled at edge j in ESC_AMBOS -> MOTOR2=0 from cycle j, MOTOR1=1 in j..j+1, MOTOR1=0 and ESTADO=0 from j+2.
- Mode latch: start with MODO=1, toggle MODO to 0 at k+3 and k+12 -> waveform identical to the alternating scenario.
- Alternating abort: drop ARRANQUE at edge k+12 (in ALT_M2) -> MOTOR2=0 and ESTADO=0 from cycle k+12, with no gap or run-down.
- Reset mid-run: in ESC_AMBOS, assert REINICIO=0 at edge j with ARRANQUE=1 -> both motors 0 from cycle j, PARADA is never visited; after release, a fresh start latches the current MODO.
